// File: rtl/wb_dma_copy.sv
// Single-channel Wishbone memory-to-memory word copier.
// Config slave programs SRC/DST/LEN/CTRL; master copies one word per six cycles minimum.
module wb_dma_copy #(
    parameter int LEN_W = 16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        irq_o
);

    typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;

    state_t             state;
    logic [31:0]        src_r, dst_r, wsrc, wdst, data_r, rdata;
    logic [LEN_W-1:0]   len_r, cnt;
    logic               busy, done, err, ie;
    logic               acc;
    logic               unused_ok;

    assign acc       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    always_comb begin
        rdata = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0: rdata = src_r;
            2'd1: rdata = dst_r;
            2'd2: rdata = 32'(len_r);
            2'd3: rdata = {27'd0, ie, err, done, busy, 1'b0};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state     <= IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            wsrc      <= '0;
            wdst      <= '0;
            cnt       <= '0;
            data_r    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ie        <= 1'b0;
            irq_o     <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            irq_o     <= ie & (done | err);
            if (acc) wbs_dat_o <= rdata;

            if (acc && wbs_we_i) begin
                case (wbs_adr_i[3:2])
                    2'd0: if (!busy) src_r <= wbs_dat_i;
                    2'd1: if (!busy) dst_r <= wbs_dat_i;
                    2'd2: if (!busy) len_r <= wbs_dat_i[LEN_W-1:0];
                    default: begin
                        if (wbs_dat_i[2]) done <= 1'b0;
                        if (wbs_dat_i[3]) err  <= 1'b0;
                        if (!busy) ie <= wbs_dat_i[4];
                        if (!busy && wbs_dat_i[0]) begin
                            err  <= 1'b0;
                            wsrc <= src_r;
                            wdst <= dst_r;
                            cnt  <= len_r;
                            // Empty copy completes immediately without touching the bus
                            if (len_r == '0) begin
                                done <= 1'b1;
                            end else begin
                                done      <= 1'b0;
                                busy      <= 1'b1;
                                state     <= RD;
                                wbm_cyc_o <= 1'b1;
                                wbm_stb_o <= 1'b1;
                                wbm_we_o  <= 1'b0;
                                wbm_adr_o <= src_r;
                                wbm_sel_o <= 4'hF;
                            end
                        end
                    end
                endcase
            end

            case (state)
                IDLE: ;
                RD: begin
                    // cyc low while in RD is the one-cycle pause after a retry
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                    end else if (wbm_err_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_rty_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                    end else if (wbm_ack_i) begin
                        data_r    <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= RGAP;
                    end
                end
                RGAP: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= wdst;
                    wbm_dat_o <= data_r;
                    state     <= WR;
                end
                WR: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                    end else if (wbm_err_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_rty_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        state     <= WGAP;
                    end
                end
                WGAP: begin
                    wsrc <= wsrc + 32'd4;
                    wdst <= wdst + 32'd4;
                    cnt  <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_adr_o <= wsrc + 32'd4;
                        state     <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: registered-ack RAM slave with
// injectable err/rty, and a word-copy reference model computed from memory contents.
module tb_wb_dma_copy;

    logic        clk = 1'b0;
    logic        nrst_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        irq_o;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [31:0] s_dat = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_dma_copy #(.LEN_W(16)) dut (
        .clk_i(clk), .nrst_i(nrst_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbs_rty_o(wbs_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty),
        .irq_o(irq_o)
    );

    // Memory model: unwritten words hold a salted hash of their address
    logic [31:0] salt = 32'd0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$], wa_log[$], wd_log[$], aa_log[$], ad_log[$];
    int          at_log[$];
    int          cyc_n = 0, rd_cnt = 0, wr_att = 0;
    int          err_at_rd = 0, rty_until = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        s_ack <= 1'b0;
        s_err <= 1'b0;
        s_rty <= 1'b0;
        if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && !(s_ack || s_err || s_rty)) begin
            if (!wbm_we_o) begin
                rd_cnt = rd_cnt + 1;
                if (rd_cnt == err_at_rd) begin
                    s_err <= 1'b1;
                end else begin
                    s_ack <= 1'b1;
                    s_dat <= mem_rd(wbm_adr_o);
                    rd_log.push_back(wbm_adr_o);
                end
            end else begin
                wr_att = wr_att + 1;
                aa_log.push_back(wbm_adr_o);
                ad_log.push_back(wbm_dat_o);
                at_log.push_back(cyc_n);
                if (wr_att <= rty_until) begin
                    s_rty <= 1'b1;
                end else begin
                    s_ack <= 1'b1;
                    mem[wbm_adr_o] = wbm_dat_o;
                    wa_log.push_back(wbm_adr_o);
                    wd_log.push_back(wbm_dat_o);
                end
            end
        end
    end

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (wbs_ack_o !== 1'b1 && n < 20);
        if (wbs_ack_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wb_write_timeout adr=%h got no ack, required ack", a);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        wbs_adr_i = a; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (wbs_ack_o !== 1'b1 && n < 20);
        if (wbs_ack_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wb_read_timeout adr=%h got no ack, required ack", a);
        end
        d = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic program_start(input logic [31:0] s, input logic [31:0] d,
                                 input logic [31:0] len, input logic [31:0] ctrl);
        wb_write(4'h0, s);
        wb_write(4'h4, d);
        wb_write(4'h8, len);
        wb_write(4'hC, ctrl);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (irq_o !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        acked;
        nrst_i = 1'b0;
        wbs_adr_i = 4'h0; wbs_dat_i = 32'd0; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        acked = 1'b0;
        repeat (4) begin @(negedge clk); if (wbs_ack_o !== 1'b0) acked = 1'b1; end
        checks++;
        if (acked !== 1'b0) begin
            errors++; $display("FAIL reset_no_ack got ack=1 required 0");
        end
        checks++;
        if ({wbs_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_cyc_o,
             wbm_stb_o, wbm_we_o, irq_o, wbs_err_o, wbs_rty_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got adr=%h dat=%h sdat=%h cyc=%b irq=%b required all 0",
                     wbm_adr_o, wbm_dat_o, wbs_dat_o, wbm_cyc_o, irq_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        nrst_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wb_read(4'(r * 4), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL reset_reg%0d got %h required 0", r, v);
            end
        end
    endtask

    task automatic test_copy();
        int          rb, wb, n;
        logic [31:0] e[3];
        logic [31:0] v;
        logic        ok;
        rb = rd_log.size(); wb = wa_log.size();
        for (int i = 0; i < 3; i++) e[i] = mem_rd(32'h1000 + 32'(4 * i));
        program_start(32'h1000, 32'h2000, 32'd3, 32'h11);
        wait_irq(n);
        checks++;
        if (n !== 19) begin
            errors++; $display("FAIL copy_cycles got %0d required 19", n);
        end
        ok = (rd_log.size() - rb == 3) && (wa_log.size() - wb == 3);
        if (ok) for (int i = 0; i < 3; i++)
            if (rd_log[rb+i] !== 32'h1000 + 32'(4*i) || wa_log[wb+i] !== 32'h2000 + 32'(4*i)
                || wd_log[wb+i] !== e[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL copy_data got %0d reads %0d writes required 3/3 with matching adr/dat",
                     rd_log.size() - rb, wa_log.size() - wb);
        end
        wb_read(4'hC, v);
        checks++;
        if (v !== 32'h14) begin
            errors++; $display("FAIL copy_ctrl got %h required 14", v);
        end
        wb_read(4'h0, v);
        checks++;
        if (v !== 32'h1000) begin
            errors++; $display("FAIL copy_src_kept got %h required 1000", v);
        end
        wb_write(4'hC, 32'h14);
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL copy_irq_clear got %b required 0", irq_o);
        end
    endtask

    task automatic test_zero_len();
        int          rb;
        logic        seen;
        logic [31:0] v;
        rb = rd_log.size();
        program_start(32'h1100, 32'h2100, 32'd0, 32'h11);
        seen = 1'b0;
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin
            errors++; $display("FAIL zero_irq got %b required 1", irq_o);
        end
        repeat (6) begin if (wbm_cyc_o !== 1'b0) seen = 1'b1; @(negedge clk); end
        checks++;
        if (seen || rd_log.size() != rb) begin
            errors++; $display("FAIL zero_no_bus got cyc_seen=%b required 0", seen);
        end
        wb_read(4'hC, v);
        checks++;
        if (v !== 32'h14) begin
            errors++; $display("FAIL zero_ctrl got %h required 14", v);
        end
        wb_write(4'hC, 32'h04);
    endtask

    task automatic test_start_busy();
        int          rb, wb, n;
        logic [31:0] e[4];
        logic [31:0] v;
        logic        ok;
        rb = rd_log.size(); wb = wa_log.size();
        for (int i = 0; i < 4; i++) e[i] = mem_rd(32'h3000 + 32'(4 * i));
        program_start(32'h3000, 32'h4000, 32'd4, 32'h01);
        program_start(32'h5000, 32'h6000, 32'd9, 32'h01);
        wb_read(4'hC, v);
        checks++;
        if (v !== 32'h02) begin
            errors++; $display("FAIL busy_ctrl got %h required 02", v);
        end
        wb_read(4'h0, v);
        checks++;
        if (v !== 32'h3000) begin
            errors++; $display("FAIL busy_src_ignored got %h required 3000", v);
        end
        n = 0;
        do begin wb_read(4'hC, v); n++; end while (v[2] !== 1'b1 && n < 60);
        checks++;
        if (v !== 32'h04) begin
            errors++; $display("FAIL busy_done got ctrl=%h required 04", v);
        end
        ok = (rd_log.size() - rb == 4) && (wa_log.size() - wb == 4);
        if (ok) for (int i = 0; i < 4; i++)
            if (rd_log[rb+i] !== 32'h3000 + 32'(4*i) || wa_log[wb+i] !== 32'h4000 + 32'(4*i)
                || wd_log[wb+i] !== e[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_restart_ignored got %0d reads %0d writes required 4/4 original",
                     rd_log.size() - rb, wa_log.size() - wb);
        end
        wb_write(4'hC, 32'h04);
    endtask

    task automatic test_err();
        int          rb, wb, n;
        logic [31:0] v;
        rb = rd_log.size(); wb = wa_log.size();
        err_at_rd = rd_cnt + 2;
        program_start(32'h7000, 32'h8000, 32'd4, 32'h11);
        n = 0;
        while (s_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (s_err !== 1'b1 || wbm_cyc_o !== 1'b1) begin
            errors++; $display("FAIL err_seen got err=%b cyc=%b required 1/1", s_err, wbm_cyc_o);
        end
        @(negedge clk);
        checks++;
        if (wbm_cyc_o !== 1'b0) begin
            errors++; $display("FAIL err_cyc_drop got %b required 0", wbm_cyc_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (wa_log.size() - wb != 1 || rd_log.size() - rb != 1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL err_counts got writes=%0d reads=%0d irq=%b required 1/1/1",
                     wa_log.size() - wb, rd_log.size() - rb, irq_o);
        end
        wb_read(4'hC, v);
        checks++;
        if (v !== 32'h18) begin
            errors++; $display("FAIL err_ctrl got %h required 18", v);
        end
        err_at_rd = 0;
        wb_write(4'hC, 32'h08);
    endtask

    task automatic test_rty();
        int          ab, wb, n;
        logic [31:0] e[2];
        logic        ok;
        ab = aa_log.size(); wb = wa_log.size();
        for (int i = 0; i < 2; i++) e[i] = mem_rd(32'h9000 + 32'(4 * i));
        rty_until = wr_att + 2;
        program_start(32'h9000, 32'hA000, 32'd2, 32'h11);
        wait_irq(n);
        checks++;
        if (n !== 19) begin
            errors++; $display("FAIL rty_cycles got %0d required 19", n);
        end
        ok = (aa_log.size() - ab == 4);
        if (ok) for (int i = 0; i < 3; i++)
            if (aa_log[ab+i] !== 32'hA000 || ad_log[ab+i] !== e[0]) ok = 1'b0;
        if (ok && (at_log[ab+1] - at_log[ab] != 3 || at_log[ab+2] - at_log[ab+1] != 3)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rty_attempts got %0d attempts required 4 with identical retries",
                               aa_log.size() - ab);
        end
        checks++;
        if (wa_log.size() - wb != 2 || wd_log[wb] !== e[0] || wd_log[wb+1] !== e[1]
            || wa_log[wb+1] !== 32'hA004) begin
            errors++; $display("FAIL rty_data got %0d writes required 2 matching", wa_log.size() - wb);
        end
        rty_until = 0;
        wb_write(4'hC, 32'h04);
    endtask

    task automatic test_wrap();
        int rb, n;
        rb = rd_log.size();
        program_start(32'hFFFF_FFFC, 32'hB000, 32'd2, 32'h11);
        wait_irq(n);
        checks++;
        if (rd_log.size() - rb != 2 || rd_log[rb] !== 32'hFFFF_FFFC || rd_log[rb+1] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got %0d reads, second=%h required 00000000",
                               rd_log.size() - rb, rd_log[rd_log.size()-1]);
        end
        wb_write(4'hC, 32'h04);
    endtask

    task automatic test_reset_mid();
        int          wb, n;
        logic [31:0] v;
        wb = wa_log.size();
        program_start(32'hC000, 32'hD000, 32'd4, 32'h11);
        n = 0;
        while (!(wbm_cyc_o === 1'b1 && wbm_we_o === 1'b1 && wa_log.size() - wb == 2) && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL midrst_reach got timeout required third write");
        end
        nrst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL midrst_drop got cyc=%b stb=%b irq=%b required 0",
                               wbm_cyc_o, wbm_stb_o, irq_o);
        end
        nrst_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wb_read(4'(r * 4), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL midrst_reg%0d got %h required 0", r, v);
            end
        end
    endtask

    task automatic test_random();
        int          rb, wb, n, len;
        logic [31:0] s, d;
        logic [31:0] e[$];
        logic        ok;
        for (int k = 0; k < 5; k++) begin
            s = $urandom & 32'hFFFF_FFFC;
            d = s + 32'h0010_0000;
            len = $urandom_range(1, 5);
            e.delete();
            for (int i = 0; i < len; i++) e.push_back(mem_rd(s + 32'(4 * i)));
            rb = rd_log.size(); wb = wa_log.size();
            program_start(s, d, 32'(len), 32'h11);
            wait_irq(n);
            ok = (n == 6 * len + 1) && (rd_log.size() - rb == len) && (wa_log.size() - wb == len);
            if (ok) for (int i = 0; i < len; i++)
                if (rd_log[rb+i] !== s + 32'(4*i) || wa_log[wb+i] !== d + 32'(4*i)
                    || wd_log[wb+i] !== e[i]) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random%0d got cycles=%0d writes=%0d required cycles=%0d writes=%0d",
                         k, n, wa_log.size() - wb, 6 * len + 1, len);
            end
            wb_write(4'hC, 32'h04);
        end
    endtask

    initial begin
        salt = $urandom;
        nrst_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        test_reset();
        test_copy();
        test_zero_len();
        test_start_busy();
        test_err();
        test_rty();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
